led_throbber: RTL
=================

# led_throbber

Multi-channel LED driver; parametrised successor to the single hard-wired heartbeat counter in the board top level. It generates a shared prescaler tick and drives CHANNELS registered LED outputs. Each output is independently OFF, ON, BLINK at a programmable half-period, or BREATHE (triangle-ramped PWM). It sits between board top level (`main`) and `chan[]` pins; config arrives through a single-cycle write port.

## Interface
- `CHANNELS`, 4, number of LED outputs (1..16).
- `CLOCK_HZ`, 12_000_000, frequency of `clock`.
- `TICK_HZ`, 1000, prescaler tick rate; `DIV = CLOCK_HZ/TICK_HZ`, must be ≥2.
- `PERIOD_W`, 16, width of per-channel half-period, in ticks.
- `PWM_W`, 8, breathe brightness / PWM counter width.
- `DEFAULT_HALF`, 499, channel-0 half-period after reset.
- `clock`  in  1  system clock; only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  config write strobe, one cycle per write.
- `wr_chan`  in  4  target channel index.
- `wr_mode`  in  2  00 OFF, 01 ON, 10 BLINK, 11 BREATHE.
- `wr_half`  in  PERIOD_W  half-period in ticks.
- `sync`  in  1  one-cycle pulse; phase-aligns all channels.
- `tick`  out  1  prescaler tick, one cycle wide.
- `led`  out  CHANNELS  registered LED drive, active-high.

## Operation
- Reset (async): prescaler = 0, `tick` = 0, `led` = 0, all phase counters/levels/directions = 0. Channel 0 mode = BLINK, half = DEFAULT_HALF. Other channels OFF, half = 0.
- Prescaler: counts 0..DIV-1. When at DIV-1 it wraps to 0 and `tick` = 1 for that one cycle.
- Per channel, on `tick` in BLINK/BREATHE: if `cnt >= half`, set `cnt` ← 0 and take a step; else `cnt` ← `cnt+1`. This gives a step every half+1 ticks. `>=` keeps it safe when half is lowered mid-count.
- BLINK step: toggle `state`; `led[i]` = `state`.
- BREATHE step: `level` += 1 while rising and −= 1 while falling. Direction flips on reaching 2^PWM_W−1 (rising) or 0 (falling). No overflow or underflow.
- PWM: one shared PWM_W-bit free-running counter, +1 every clock, wraps. `led[i]` = (`pwm_cnt` < `level`). Level 0 → always 0; max level → high 255/256 (PWM_W=8).
- OFF: `led[i]` = 0. ON: `led[i]` = 1. Counters are held at 0 in both.
- Write: if `wr_en` and `wr_chan` < CHANNELS, latch mode/half. The same edge clears that channel's `cnt`, `state`, `level`, direction (rising). Writes with `wr_chan` ≥ CHANNELS are ignored.
- `sync`: clears `cnt`, `state`, `level`, direction of all channels; mode/half unchanged. The prescaler is not reset.
- Write coinciding with `sync`: the write's mode/half apply and all channels clear.
- Write or `sync` coinciding with `tick`: the clear wins; no step occurs that cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (async); operation restarts from the reset config on the first edge after deassert.

## Timing
- `tick`, `led` are registers; no combinational input→output path.
- BLINK toggle is visible on `led` the cycle after the tick edge that steps it.
- Write/`sync` clears are visible on `led` on the edge after the strobe edge.
- First channel-0 toggle after reset deassert: at tick number DEFAULT_HALF+1, i.e. (DEFAULT_HALF+1)·DIV cycles. Default: 6 000 000 cycles (0.5 s at 12 MHz).
- BREATHE full cycle = 2·(2^PWM_W−1)·(half+1) ticks.

## Configuration
- `LED_THROBBER_BREATHE_EN` defined: mode 11 = BREATHE as above; PWM counter and per-channel level/direction registers are present.
- Undefined: mode 11 behaves exactly as ON. The PWM counter and level/direction logic are not synthesised. All other behaviour is identical.

## Test plan
Bench parameters: CLOCK_HZ=100, TICK_HZ=10 (DIV=10), DEFAULT_HALF=2, PWM_W=4.
- Reset, release, idle → `tick` pulses every 10 cycles. `led[0]` rises after 30 cycles, falls after 60; `led[3:1]` stay 0.
- Write ch1 BLINK half=0 → `led[1]` toggles on every tick (period 20 cycles). Then write half=5 mid-count with cnt=3 → next toggle 6 ticks after the write.
- With breathe enabled: write ch2 BREATHE half=0 → level ramps 0→15→0 over 30 ticks. At level 4, `led[2]` high 4 of every 16 cycles. At level 15, high 15/16.
- Write ch2 mode 11 with breathe disabled → `led[2]` = 1 constantly from the next cycle.
- Write ch1 BLINK while `led[1]`=1, same cycle as `tick`, with `sync` also asserted → all `led` in BLINK/BREATHE drop to 0 next cycle; no step taken that tick.
- `wr_chan`=7 with CHANNELS=4 → no state change. Assert reset mid-blink → `led`=0 asynchronously before the next clock edge.

Source files
------------

// File: rtl/led_throbber_if.sv
// ============================================================================
// Module   : led_throbber_if
// Purpose  : Config write port, sync strobe and LED/tick outputs of led_throbber.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface led_throbber_if #(
  parameter int CHANNELS = 4,
  parameter int PERIOD_W = 16
) ();
  logic                wr_en;
  logic [3:0]          wr_chan;
  logic [1:0]          wr_mode;
  logic [PERIOD_W-1:0] wr_half;
  logic                sync;
  logic                tick;
  logic [CHANNELS-1:0] led;

  modport master (
    output wr_en, wr_chan, wr_mode, wr_half, sync,
    input  tick, led
  );

  modport slave (
    input  wr_en, wr_chan, wr_mode, wr_half, sync,
    output tick, led
  );
endinterface

`default_nettype wire

// File: rtl/led_throbber.sv
// ============================================================================
// Module   : led_throbber
// Purpose  : Multi-channel LED driver (OFF/ON/BLINK/BREATHE) with shared tick.
//            Optional macro LED_THROBBER_BREATHE_EN enables the BREATHE mode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_throbber #(
  parameter int CHANNELS     = 4,
  parameter int CLOCK_HZ     = 12_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int PERIOD_W     = 16,
  parameter int PWM_W        = 8,
  parameter int DEFAULT_HALF = 499
) (
  input  logic         clock,
  input  logic         reset,
  led_throbber_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam int c_div     = CLOCK_HZ / TICK_HZ;
  localparam int c_presc_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(c_div - 1);

  if (c_div < 2 || CHANNELS < 1 || CHANNELS > 16 || PWM_W < 1) begin : g_bad_params
    $error("led_throbber: illegal parameter combination");
  end

  logic [c_presc_w-1:0]               presc_q, presc_d;
  logic                               tick_q, tick_d;
  logic [CHANNELS-1:0][1:0]           mode_q, mode_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0]  half_q, half_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]                state_q, state_d;
  logic [CHANNELS-1:0]                led_q, led_d;
  logic                               wr_hit;
  logic                               active;
`ifdef LED_THROBBER_BREATHE_EN
  logic [PWM_W-1:0]                   pwm_q, pwm_d;
  logic [CHANNELS-1:0][PWM_W-1:0]     level_q, level_d;
  logic [CHANNELS-1:0]                fall_q, fall_d;
`endif

  always_comb begin
    presc_d = presc_q + 1'b1;
    tick_d  = 1'b0;
    if (presc_q == c_presc_max) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
    mode_d  = mode_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    led_d   = '0;
    wr_hit  = 1'b0;
    active  = 1'b0;
`ifdef LED_THROBBER_BREATHE_EN
    pwm_d   = pwm_q + 1'b1;
    level_d = level_q;
    fall_d  = fall_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit = bus.wr_en && (bus.wr_chan == 4'(i));
`ifdef LED_THROBBER_BREATHE_EN
      active = (mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_BREATHE);
`else
      active = (mode_q[i] == MODE_BLINK);
`endif
      // A clear (write, sync, or a static mode) always beats a tick step.
      if (!active || wr_hit || bus.sync) begin
        cnt_d[i]   = '0;
        state_d[i] = 1'b0;
`ifdef LED_THROBBER_BREATHE_EN
        level_d[i] = '0;
        fall_d[i]  = 1'b0;
`endif
      end else if (tick_d) begin
        if (cnt_q[i] >= half_q[i]) begin
          cnt_d[i] = '0;
          if (mode_q[i] == MODE_BLINK) begin
            state_d[i] = ~state_q[i];
          end
`ifdef LED_THROBBER_BREATHE_EN
          else if (!fall_q[i]) begin
            level_d[i] = level_q[i] + 1'b1;
            if (level_d[i] == '1) fall_d[i] = 1'b1;
          end else begin
            level_d[i] = level_q[i] - 1'b1;
            if (level_d[i] == '0) fall_d[i] = 1'b0;
          end
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (wr_hit) begin
        mode_d[i] = bus.wr_mode;
        half_d[i] = bus.wr_half;
      end
      case (mode_d[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = state_d[i];
`ifdef LED_THROBBER_BREATHE_EN
        default:    led_d[i] = (pwm_d < level_d[i]);
`else
        default:    led_d[i] = 1'b1;
`endif
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      mode_q    <= '0;
      mode_q[0] <= MODE_BLINK;
      half_q    <= '0;
      half_q[0] <= PERIOD_W'(DEFAULT_HALF);
      cnt_q     <= '0;
      state_q   <= '0;
      led_q     <= '0;
`ifdef LED_THROBBER_BREATHE_EN
      pwm_q     <= '0;
      level_q   <= '0;
      fall_q    <= '0;
`endif
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      mode_q    <= mode_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      led_q     <= led_d;
`ifdef LED_THROBBER_BREATHE_EN
      pwm_q     <= pwm_d;
      level_q   <= level_d;
      fall_q    <= fall_d;
`endif
    end
  end

  assign bus.tick = tick_q;
  assign bus.led  = led_q;

endmodule

`default_nettype wire
